// File: rtl/conware_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : conware_seq_if
// Brief   : Input-board / result-board handshake bundle for conware_seq.
// Revision: 1.0 - initial release
// ============================================================================
interface conware_seq_if #(
   parameter int N = 16
) ();
   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   // Buffer side: supplies boards, consumes results.
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   // Sequencer side.
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/conware_seq.sv
`default_nettype none
// ============================================================================
// Module  : conware_seq
// Brief   : Runs a Game-of-Life board through gen_count generations using
//           external next-state logic. Optional still-life early exit is
//           enabled by defining CONWARE_SEQ_EARLY_EXIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module conware_seq #(
   parameter  int WIDTH  = 4,
   parameter  int HEIGHT = 4,
   parameter  int GWIDTH = 16,
   localparam int N      = WIDTH * HEIGHT
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              start,
   input  wire logic [GWIDTH-1:0] gen_count,
   conware_seq_if.slave           bus,
   output      logic [N-1:0]      cur_states,
   input  wire logic [N-1:0]      next_states,
   output      logic              busy,
   output      logic              done,
   output      logic [GWIDTH-1:0] gens_run,
   output      logic              stable
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ITER   = 2'd2,
      ST_UNLOAD = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      board_q, board_d;
   logic [GWIDTH-1:0] remaining_q, remaining_d;
   logic [GWIDTH-1:0] gens_q, gens_d;
   logic              stable_q, stable_d;
   logic              done_q, done_d;
   logic              in_ready;
   logic              out_valid;
   logic              still;

`ifdef CONWARE_SEQ_EARLY_EXIT_EN
   assign still = (next_states == board_q);
`else
   assign still = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      remaining_d = remaining_q;
      gens_d      = gens_q;
      stable_d    = stable_q;
      done_d      = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               remaining_d = gen_count;
               gens_d      = '0;
               stable_d    = 1'b0;
               state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               board_d = bus.in_data;
               state_d = (remaining_q == '0) ? ST_UNLOAD : ST_ITER;
            end
         end
         ST_ITER: begin
            // A still life freezes the board and ends the run without counting.
            if (still) begin
               stable_d = 1'b1;
               state_d  = ST_UNLOAD;
            end else begin
               board_d     = next_states;
               remaining_d = remaining_q - 1'b1;
               gens_d      = gens_q + 1'b1;
               if (remaining_q == GWIDTH'(1)) begin
                  state_d = ST_UNLOAD;
               end
            end
         end
         ST_UNLOAD: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         board_q     <= '0;
         remaining_q <= '0;
         gens_q      <= '0;
         stable_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         remaining_q <= remaining_d;
         gens_q      <= gens_d;
         stable_q    <= stable_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = board_q;
   assign cur_states    = board_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign gens_run      = gens_q;
   assign stable        = stable_q;

endmodule
`default_nettype wire

// File: doc/conware_seq.md
CONWARE_SEQ -- requirements
Module: conware_seq

Interface
REQ-001 Parameter WIDTH, default 4, board columns.
REQ-002 Parameter HEIGHT, default 4, board rows; board vector width N = WIDTH*HEIGHT, cell (r,c) at bit r*WIDTH+c.
REQ-003 Parameter GWIDTH, default 16, width of generation counters.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  run request, sampled only in IDLE.
REQ-007 gen_count  input  GWIDTH  generations to compute, latched with start.
REQ-008 in_data  input  N  board from input buffer.
REQ-009 in_valid / in_ready  input / output  1 each  input-board handshake.
REQ-010 cur_states  output  N  current board, drives external conway next-state logic.
REQ-011 next_states  input  N  combinational next generation of cur_states.
REQ-012 out_data  output  N  result board to output buffer.
REQ-013 out_valid / out_ready  output / input  1 each  result handshake.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse when result accepted.
REQ-016 gens_run  output  GWIDTH  generations completed in current/last run.
REQ-017 stable  output  1  still-life early-exit flag (see Configuration).

Function
REQ-018 FSM states IDLE, LOAD, ITER, UNLOAD; board register B drives cur_states and out_data continuously.
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 -> remaining<=gen_count, gens_run<=0, stable<=0, next state LOAD.
REQ-020 start while busy shall be ignored, no queuing.
REQ-021 LOAD: in_ready=1; on in_valid&&in_ready, B<=in_data; go UNLOAD if remaining==0, else ITER.
REQ-022 ITER: every cycle B<=next_states, remaining<=remaining-1, gens_run<=gens_run+1; one generation per clock, no stalls.
REQ-023 ITER exits to UNLOAD on the cycle that computes the last generation (remaining==1); latency from board accept to out_valid = gen_count+1 cycles (1 if gen_count==0).
REQ-024 UNLOAD: out_valid=1, B frozen; on out_valid&&out_ready -> IDLE with done=1 for exactly that following cycle.
REQ-025 out_valid shall stay high, out_data stable, until accepted; out_ready low indefinitely holds UNLOAD.
REQ-026 gens_run saturates never: bounded by gen_count, holds value in IDLE until next start.
REQ-027 gen_count all-ones shall run exactly 2^GWIDTH-1 generations.
REQ-028 in_valid asserted outside LOAD shall not be consumed.

Reset
REQ-029 rst=1 at any edge, including mid-ITER or mid-UNLOAD: state<=IDLE, B<=0, remaining<=0, gens_run<=0, stable<=0.
REQ-030 Reset output values: in_ready=0, out_valid=0, busy=0, done=0, cur_states=0, out_data=0.
REQ-031 rst has priority over start and all handshakes in the same cycle.

Configuration
REQ-032 Macro CONWARE_SEQ_EARLY_EXIT_EN defined: in ITER, if next_states==B, B unchanged, stable<=1, gens_run not incremented, go UNLOAD next cycle.
REQ-033 Macro undefined: no comparison, stable tied 0, ITER always runs full gen_count.

Verification
REQ-034 gen_count=0, in_data=0x0070 -> out_valid 1 cycle after accept, out_data=0x0070, gens_run=0.
REQ-035 Blinker 0x0070, gen_count=3 -> out_data=0x0222, gens_run=3, done pulse after out_ready.
REQ-036 Block 0x0660, gen_count=10 -> with macro: out_data=0x0660, gens_run=0, stable=1; without: gens_run=10, stable=0.
REQ-037 out_ready held 0 for 20 cycles in UNLOAD -> out_valid/out_data stable, second start ignored, busy=1.
REQ-038 rst asserted mid-ITER (gen_count=100, after 5 cycles) -> next cycle IDLE, all outputs at reset values.
